// File: rtl/mux_pair_rx.sv
// mux_pair_rx: re-pairs sel=0/sel=1 halves of a muxed bus into one word pair.
// Ports: din/din_sel/din_valid/din_ready in; out1/out2/out_valid/out_ready out; seq_err, pair_cnt.
module mux_pair_rx #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     din,
  input  logic             din_sel,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [W-1:0]     out1,
  output logic [W-1:0]     out2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             seq_err,
  output logic [CNT_W-1:0] pair_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [W-1:0] a_q;
  logic         acc;
  logic         load_a;
  logic         load_pair;
  logic         clr_valid;
  logic         err_d;

  // Ready never looks at din_valid; in FULL it opens only when the pair drains.
  assign din_ready = ~rst & ((state_q != FULL) | out_ready);
  assign acc       = din_valid & din_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (acc && !din_sel) state_d = HALF;
      end
      HALF: begin
        if (acc && din_sel) state_d = FULL;
      end
      FULL: begin
        if (out_ready) begin
          if (acc && !din_sel) state_d = HALF;
          else                 state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    load_a    = 1'b0;
    load_pair = 1'b0;
    clr_valid = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          load_a = !din_sel;
          err_d  = din_sel;
        end
      end
      HALF: begin
        if (acc) begin
          load_pair = din_sel;
          load_a    = !din_sel;
          err_d     = !din_sel;
        end
      end
      FULL: begin
        // acc here implies out_ready, so the drain and accept coincide.
        clr_valid = out_ready;
        if (acc) begin
          load_a = !din_sel;
          err_d  = din_sel;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      out1      <= '0;
      out2      <= '0;
      out_valid <= 1'b0;
      seq_err   <= 1'b0;
      pair_cnt  <= '0;
    end else begin
      seq_err <= err_d;
      if (load_a) a_q <= din;
      if (load_pair) begin
        out1      <= a_q;
        out2      <= din;
        out_valid <= 1'b1;
        pair_cnt  <= pair_cnt + 1'b1;
      end else if (clr_valid) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_pair_rx.sv
// tb_mux_pair_rx: directed + random checks of mux_pair_rx against a pairing model.
// Two instances share inputs: default counter width and a 4-bit counter for wrap.
module tb_mux_pair_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_sel;
  logic       din_valid;
  logic       out_ready;

  logic        din_ready, out_valid, seq_err;
  logic [7:0]  out1, out2;
  logic [15:0] pair_cnt;

  logic       din_ready4, out_valid4, seq_err4;
  logic [7:0] out1_4, out2_4;
  logic [3:0] pair_cnt4;

  int vectors = 0;
  int miscompares = 0;

  // reference model: optional pending first half, optional output pair
  bit       m_have_a;
  bit [7:0] m_a;
  bit       m_full;
  bit [7:0] m_o1, m_o2;
  int       m_cnt;
  bit       m_err;

  always #5 clk = ~clk;

  mux_pair_rx u_dut (
    .clk(clk), .rst(rst), .din(din), .din_sel(din_sel),
    .din_valid(din_valid), .din_ready(din_ready),
    .out1(out1), .out2(out2), .out_valid(out_valid),
    .out_ready(out_ready), .seq_err(seq_err), .pair_cnt(pair_cnt)
  );

  mux_pair_rx #(.W(8), .CNT_W(4)) u_w4 (
    .clk(clk), .rst(rst), .din(din), .din_sel(din_sel),
    .din_valid(din_valid), .din_ready(din_ready4),
    .out1(out1_4), .out2(out2_4), .out_valid(out_valid4),
    .out_ready(out_ready), .seq_err(seq_err4), .pair_cnt(pair_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input bit s,
                            input bit [7:0] d, input bit o);
    bit rdy;
    if (r) begin
      m_have_a = 0; m_a = 0; m_full = 0;
      m_o1 = 0; m_o2 = 0; m_cnt = 0; m_err = 0;
      return;
    end
    rdy = !m_full || o;
    m_err = 0;
    if (m_full && o) m_full = 0;
    if (v && rdy) begin
      if (!s) begin
        if (m_have_a) m_err = 1;
        m_have_a = 1;
        m_a = d;
      end else if (m_have_a) begin
        m_o1 = m_a;
        m_o2 = d;
        m_full = 1;
        m_cnt++;
        m_have_a = 0;
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input bit s,
                      input bit [7:0] d, input bit o);
    rst = r; din_valid = v; din_sel = s; din = d; out_ready = o;
    #1;
    chk("din_ready", din_ready, !r && (!m_full || o));
    chk("din_ready4", din_ready4, !r && (!m_full || o));
    @(posedge clk);
    model_edge(r, v, s, d, o);
    #1;
    chk("out_valid", out_valid, m_full);
    chk("out1", out1, m_o1);
    chk("out2", out2, m_o2);
    chk("seq_err", seq_err, m_err);
    chk("pair_cnt", pair_cnt, m_cnt % 65536);
    chk("pair_cnt4", pair_cnt4, m_cnt % 16);
    chk("out_valid4", out_valid4, m_full);
  endtask

  initial begin
    bit [7:0] a, b;
    rst = 1; din_valid = 0; din_sel = 0; din = 0; out_ready = 0;
    @(posedge clk); #1;

    step(1, 1, 0, 8'h5A, 1);
    step(1, 0, 0, 8'h00, 1);
    chk("reset_valid", out_valid, 0);
    chk("reset_cnt", pair_cnt, 0);

    // basic pair
    step(0, 1, 0, 8'hF0, 1);
    step(0, 1, 1, 8'hCC, 1);
    chk("pair_out1", out1, 8'hF0);
    chk("pair_out2", out2, 8'hCC);
    chk("pair_cnt1", pair_cnt, 1);
    step(0, 0, 0, 8'h00, 1);

    // back-pressure then drain with simultaneous first half
    step(0, 1, 0, 8'h55, 0);
    step(0, 1, 1, 8'h66, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 8'h99, 0);
      chk("bp_ready", din_ready, 0);
      chk("bp_out1", out1, 8'h55);
    end
    step(0, 1, 0, 8'h11, 1);
    chk("drain_acc_valid", out_valid, 0);
    step(0, 1, 1, 8'h22, 1);
    chk("drain_acc_out1", out1, 8'h11);
    step(0, 0, 0, 8'h00, 1);

    // sequence errors
    step(0, 1, 1, 8'hAA, 1);
    chk("err_empty", seq_err, 1);
    chk("err_empty_valid", out_valid, 0);
    step(0, 0, 0, 8'h00, 1);
    chk("err_clear", seq_err, 0);
    step(0, 1, 0, 8'h01, 1);
    step(0, 1, 0, 8'h02, 1);
    chk("err_half", seq_err, 1);
    step(0, 1, 1, 8'h03, 1);
    chk("err_half_out1", out1, 8'h02);
    chk("err_half_out2", out2, 8'h03);
    step(0, 1, 1, 8'h04, 1);
    step(0, 1, 1, 8'h05, 1);
    chk("err_b2b", seq_err, 1);

    // reset in HALF and in FULL
    step(0, 1, 0, 8'h77, 1);
    step(1, 0, 0, 8'h00, 1);
    step(0, 1, 1, 8'h88, 1);
    step(0, 1, 0, 8'h99, 1);
    step(0, 1, 1, 8'h9A, 1);
    chk("rst_half_out1", out1, 8'h99);
    step(1, 0, 0, 8'h00, 0);
    chk("rst_full_valid", out_valid, 0);
    chk("rst_full_cnt", pair_cnt, 0);

    // streaming 100 pairs
    for (int i = 0; i < 100; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      step(0, 1, 0, a, 1);
      step(0, 1, 1, b, 1);
    end
    chk("stream_cnt", pair_cnt, 100);

    // counter wrap on the 4-bit instance
    step(1, 0, 0, 8'h00, 1);
    for (int i = 1; i <= 17; i++) begin
      step(0, 1, 0, 8'(i), 1);
      step(0, 1, 1, 8'(i + 100), 1);
      if (i >= 15) chk("wrap_cnt4", pair_cnt4, i % 16);
    end

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, 8'($urandom),
           $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_pair_rx.md
# mux_pair_rx

Receive-side deserializer for the time-multiplexed 8-bit bus driven by the 16-to-8 mux. It captures the `sel=0` word and the `sel=1` word from a shared `din` stream and re-pairs them into two parallel output words. It presents each pair on a valid/ready output with a one-deep buffer and back-pressure. It also flags out-of-order halves and counts delivered pairs.

## Interface
Parameters:
- `W`, 8, data width of each half-word.
- `CNT_W`, 16, width of the delivered-pair counter.

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-high; sampled on `clk` rising edge.
- `din`  in  W  multiplexed data word.
- `din_sel`  in  1  half tag for `din`: 0 = first half (`in1`), 1 = second half (`in2`).
- `din_valid`  in  1  `din`/`din_sel` valid this cycle.
- `din_ready`  out  1  block accepts `din` this cycle. Combinational.
- `out1`  out  W  paired first-half word. Registered.
- `out2`  out  W  paired second-half word. Registered.
- `out_valid`  out  1  `out1`/`out2` hold a pair. Registered.
- `out_ready`  in  1  consumer accepts the pair this cycle.
- `seq_err`  out  1  one-cycle pulse on a sequence violation. Registered.
- `pair_cnt`  out  CNT_W  count of pairs produced. Registered.

## Operation
- Accept event: `acc = din_valid & din_ready`. Drain event: `drn = out_valid & out_ready`.
- `din_ready = ~rst & ((state != FULL) | out_ready)`.
- Hold register `a_q[W]` stores the first half.
- States and transitions:
  - **EMPTY**
    - acc with sel=0: `a_q<=din`, go to HALF.
    - acc with sel=1: word dropped, `seq_err` pulses, stay in EMPTY.
    - no acc: stay.
  - **HALF**
    - acc with sel=1: `out1<=a_q`, `out2<=din`, `out_valid<=1`, `pair_cnt++`, go to FULL.
    - acc with sel=0: `a_q<=din` (overwrite), `seq_err` pulses, stay in HALF.
    - no acc: stay.
  - **FULL** (`out_valid=1`; `out1`/`out2` held stable until drn)
    - no drn: `din_ready=0`, stay.
    - drn, no acc: `out_valid<=0`, go to EMPTY.
    - drn and acc with sel=0: `out_valid<=0`, `a_q<=din`, go to HALF.
    - drn and acc with sel=1: `out_valid<=0`, word dropped, `seq_err` pulses, go to EMPTY.
- `pair_cnt` wraps modulo 2^CNT_W. All-ones +1 gives 0, with no flag.
- `seq_err` is high for exactly one cycle per violating accept. Back-to-back violations give back-to-back pulses.
- `out1`/`out2` retain their last pair after a drain. Only `out_valid` qualifies them.

## Timing
- Reset (`rst=1` at an edge) forces:
  - state EMPTY
  - `a_q=0`, `out1=0`, `out2=0`
  - `out_valid=0`, `seq_err=0`, `pair_cnt=0`
- `din_ready=0` combinationally while `rst=1`. It is 1 in the first cycle after reset deassertion.
- Reset mid-operation discards any held half and any undrained pair. No `seq_err` is generated by the reset.
- Latency: second half accepted at edge k → `out_valid=1` with data, and `pair_cnt` incremented, in the cycle following edge k.
- Throughput: one pair every 2 cycles with `out_ready` tied high. In the FULL+drn+sel=0 case the next first half is accepted in the same cycle as the drain.
- `din_ready` depends combinationally on `out_ready` and state only, never on `din_valid`.
- `seq_err` asserts the cycle after the violating accept edge.

## Test plan
- Reset, then accept `din=8'hF0, sel=0` followed by `8'hCC, sel=1`, with `out_ready=1` → next cycle `out1=8'hF0`, `out2=8'hCC`, `out_valid=1`, `pair_cnt=1`; `seq_err` never asserted.
- Back-pressure: complete a pair with `out_ready=0` for 5 cycles → `din_ready=0` and outputs stable for all 5 cycles. Raise `out_ready` with `din=8'h11, sel=0` → drained and accepted in the same cycle; state HALF.
- Sequence errors:
  - From EMPTY, `sel=1, din=8'hAA` → `seq_err` pulses once, `out_valid` stays 0.
  - From HALF, `8'h01/sel=0` then `8'h02/sel=0` then `8'h03/sel=1` → one `seq_err`, then pair `out1=8'h02`, `out2=8'h03`.
- Streaming: 100 alternating pairs, `out_ready=1`, `din_valid=1` continuously → 100 pairs at one per 2 cycles, `pair_cnt=100`, data matches the sent sequence.
- Counter wrap: `CNT_W=4`, 17 pairs → `pair_cnt` reads 15 after pair 15, 0 after pair 16, 1 after pair 17.
- Reset mid-operation:
  - `rst` in HALF → next pair uses only post-reset halves.
  - `rst` in FULL → `out_valid=0`, `pair_cnt=0` next cycle.
